// File: rtl/edge_setup_pkg.sv
`default_nettype none
// ============================================================================
// Module : edge_setup_pkg
// Brief  : Shared constants, FSM state encoding and edge vertex-index table
//          for the quad edge-function setup block.
// Rev    : 1.0  initial release
// ============================================================================
package edge_setup_pkg;

    localparam int W         = 20;
    localparam int H_VIS     = 640;
    localparam int V_VIS     = 480;
    localparam int H_TOTAL   = 800;
    localparam int V_TOTAL   = 525;
    localparam int NUM_EDGES = 6;

    typedef logic signed [W-1:0] sval_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_MUL_P = 3'd2,
        ST_MUL_N = 3'd3,
        ST_LOAD  = 3'd4
    } state_t;

    // Edges 0..2 belong to tri1 (v0,v1,v2); edges 3..5 to tri2 (v0,v2,v3).
    function automatic logic [1:0] edge_vi(input logic [2:0] k);
        case (k)
            3'd0:    edge_vi = 2'd0;
            3'd1:    edge_vi = 2'd1;
            3'd2:    edge_vi = 2'd2;
            3'd3:    edge_vi = 2'd0;
            3'd4:    edge_vi = 2'd2;
            3'd5:    edge_vi = 2'd3;
            default: edge_vi = 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] edge_vj(input logic [2:0] k);
        case (k)
            3'd0:    edge_vj = 2'd1;
            3'd1:    edge_vj = 2'd2;
            3'd2:    edge_vj = 2'd0;
            3'd3:    edge_vj = 2'd2;
            3'd4:    edge_vj = 2'd3;
            3'd5:    edge_vj = 2'd0;
            default: edge_vj = 2'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_setup_if.sv
`default_nettype none
// ============================================================================
// Module : edge_setup_if
// Brief  : Raster-timing, vertex and edge-init signal bundle for edge_setup.
// Rev    : 1.0  initial release
// ============================================================================
interface edge_setup_if;
    import edge_setup_pkg::*;

    logic [9:0] x;
    logic [9:0] y;
    sval_t      x_screen_v0, x_screen_v1, x_screen_v2, x_screen_v3;
    sval_t      y_screen_v0, y_screen_v1, y_screen_v2, y_screen_v3;
    sval_t      e0_init_t1, e1_init_t1, e2_init_t1;
    sval_t      e0_init_t2, e1_init_t2, e2_init_t2;
    logic       busy;
    logic [1:0] tri_degen;

    modport master (
        output x, y,
        output x_screen_v0, x_screen_v1, x_screen_v2, x_screen_v3,
        output y_screen_v0, y_screen_v1, y_screen_v2, y_screen_v3,
        input  e0_init_t1, e1_init_t1, e2_init_t1,
        input  e0_init_t2, e1_init_t2, e2_init_t2,
        input  busy, tri_degen
    );

    modport slave (
        input  x, y,
        input  x_screen_v0, x_screen_v1, x_screen_v2, x_screen_v3,
        input  y_screen_v0, y_screen_v1, y_screen_v2, y_screen_v3,
        output e0_init_t1, e1_init_t1, e2_init_t1,
        output e0_init_t2, e1_init_t2, e2_init_t2,
        output busy, tri_degen
    );

endinterface
`default_nettype wire

// File: rtl/edge_setup_mul.sv
`default_nettype none
// ============================================================================
// Module : setup_mul
// Brief  : WxW signed multiplier with a registered 2W-bit product (1 clk).
// Rev    : 1.0  initial release
// ============================================================================
module setup_mul
    import edge_setup_pkg::*;
(
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire sval_t                 a,
    input  wire sval_t                 b,
    output logic signed [2*W-1:0]      prod
);

    logic signed [2*W-1:0] a_ext;
    logic signed [2*W-1:0] b_ext;

    assign a_ext = {{W{a[W-1]}}, a};
    assign b_ext = {{W{b[W-1]}}, b};

    always_ff @(posedge clk) begin
        if (reset) begin
            prod <= '0;
        end else begin
            prod <= a_ext * b_ext;
        end
    end

endmodule
`default_nettype wire

// File: rtl/edge_setup.sv
`default_nettype none
// ============================================================================
// Module : edge_setup
// Brief  : Per-frame edge constant setup and per-line edge stepping for the
//          two-triangle quad rasterizer. Optional DEGEN_CULL_EN zero-area cull.
// Rev    : 1.0  initial release
// ============================================================================
module edge_setup
    import edge_setup_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   reset,
    edge_setup_if.slave bus
);

    state_t     state, state_nxt;
    logic [2:0] edge_idx;
    sval_t      sx [4];
    sval_t      sy [4];
    sval_t      c_acc  [NUM_EDGES];
    sval_t      c_fin  [NUM_EDGES];
    sval_t      c_load [NUM_EDGES];
    sval_t      e_init [NUM_EDGES];
    sval_t      b_edge [NUM_EDGES];
    sval_t      b_eff  [NUM_EDGES];
    sval_t      p_hold;
    sval_t      c_new;
    sval_t      mul_a, mul_b;
    sval_t      prod_lo;
    logic signed [2*W-1:0] prod;
    logic       unused_prod_hi;
    logic [1:0] degen, degen_nxt;

    logic trig_cond, line_cond, trig_prev, line_prev, trig_evt, line_evt;
    logic busy, latch_en, cap_p, store_c, load_en, issue_n;

    assign trig_cond = (bus.y == 10'(V_VIS)) && (bus.x == 10'd0);
    assign line_cond = (bus.y <  10'(V_VIS)) && (bus.x == 10'd0);
    assign trig_evt  = trig_cond && !trig_prev;
    assign line_evt  = line_cond && !line_prev;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (trig_evt) state_nxt = ST_LATCH;
            ST_LATCH: state_nxt = ST_MUL_P;
            ST_MUL_P: state_nxt = ST_MUL_N;
            ST_MUL_N: state_nxt = (edge_idx == 3'(NUM_EDGES - 1)) ? ST_LOAD : ST_MUL_P;
            ST_LOAD:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy     = (state != ST_IDLE);
        latch_en = (state == ST_IDLE) && trig_evt;
        issue_n  = (state == ST_MUL_N);
        cap_p    = (state == ST_MUL_N);
        store_c  = (state == ST_MUL_P) && (edge_idx != 3'd0);
        load_en  = (state == ST_LOAD);
    end

    // MUL_P issues xj*yi, MUL_N issues xi*yj; each result lands one state later.
    always_comb begin
        mul_a = issue_n ? sx[edge_vi(edge_idx)] : sx[edge_vj(edge_idx)];
        mul_b = issue_n ? sy[edge_vj(edge_idx)] : sy[edge_vi(edge_idx)];
    end

    setup_mul u_mul (
        .clk   (clk),
        .reset (reset),
        .a     (mul_a),
        .b     (mul_b),
        .prod  (prod)
    );

    assign prod_lo        = prod[W-1:0];
    assign unused_prod_hi = ^prod[2*W-1:W];
    assign c_new          = p_hold - prod_lo;

    always_comb begin
        for (int k = 0; k < NUM_EDGES; k++) begin
            b_edge[k] = sx[edge_vi(3'(k))] - sx[edge_vj(3'(k))];
            c_fin[k]  = (k == NUM_EDGES - 1) ? c_new : c_acc[k];
        end
    end

`ifdef DEGEN_CULL_EN
    sval_t area_t1, area_t2;
    always_comb begin
        area_t1   = c_fin[0] + c_fin[1] + c_fin[2];
        area_t2   = c_fin[3] + c_fin[4] + c_fin[5];
        degen_nxt = {(area_t2 == '0), (area_t1 == '0)};
        for (int k = 0; k < NUM_EDGES; k++) begin
            c_load[k] = ((k < 3) ? degen_nxt[0] : degen_nxt[1]) ? '0 : c_fin[k];
            b_eff[k]  = ((k < 3) ? degen[0]     : degen[1])     ? '0 : b_edge[k];
        end
    end
`else
    always_comb begin
        degen_nxt = 2'b00;
        for (int k = 0; k < NUM_EDGES; k++) begin
            c_load[k] = c_fin[k];
            b_eff[k]  = b_edge[k];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            trig_prev <= 1'b0;
            line_prev <= 1'b0;
            edge_idx  <= 3'd0;
            p_hold    <= '0;
            degen     <= 2'b00;
            for (int k = 0; k < 4; k++) begin
                sx[k] <= '0;
                sy[k] <= '0;
            end
            for (int k = 0; k < NUM_EDGES; k++) begin
                c_acc[k]  <= '0;
                e_init[k] <= '0;
            end
        end else begin
            trig_prev <= trig_cond;
            line_prev <= line_cond;

            if (latch_en) begin
                sx[0] <= bus.x_screen_v0;
                sx[1] <= bus.x_screen_v1;
                sx[2] <= bus.x_screen_v2;
                sx[3] <= bus.x_screen_v3;
                sy[0] <= bus.y_screen_v0;
                sy[1] <= bus.y_screen_v1;
                sy[2] <= bus.y_screen_v2;
                sy[3] <= bus.y_screen_v3;
            end

            if (state == ST_LATCH) begin
                edge_idx <= 3'd0;
            end else if (state == ST_MUL_N) begin
                edge_idx <= edge_idx + 3'd1;
            end

            if (cap_p) begin
                p_hold <= prod_lo;
            end
            // Edge k-1's N product arrives while edge k issues its P product.
            if (store_c) begin
                c_acc[edge_idx - 3'd1] <= c_new;
            end

            if (load_en) begin
                degen <= degen_nxt;
                for (int k = 0; k < NUM_EDGES; k++) begin
                    e_init[k] <= c_load[k];
                end
            end else if (line_evt) begin
                for (int k = 0; k < NUM_EDGES; k++) begin
                    e_init[k] <= e_init[k] + b_eff[k];
                end
            end
        end
    end

    assign bus.e0_init_t1 = e_init[0];
    assign bus.e1_init_t1 = e_init[1];
    assign bus.e2_init_t1 = e_init[2];
    assign bus.e0_init_t2 = e_init[3];
    assign bus.e1_init_t2 = e_init[4];
    assign bus.e2_init_t2 = e_init[5];
    assign bus.busy       = busy;
    assign bus.tri_degen  = degen;

endmodule
`default_nettype wire

// File: tb/tb_edge_setup.sv
`default_nettype none
// ============================================================================
// Module : tb_edge_setup
// Brief  : Self-checking bench for edge_setup against a vertex-level model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_edge_setup;
    import edge_setup_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    edge_setup_if bus();

    edge_setup dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef DEGEN_CULL_EN
    localparam logic [1:0] DEGEN_LIT = 2'b01;
`else
    localparam logic [1:0] DEGEN_LIT = 2'b00;
`endif

    int         checks = 0;
    int         errors = 0;
    int         vx [4];
    int         vy [4];
    longint     exp_e [6];
    longint     exp_b [6];
    logic [1:0] exp_deg;
    int         ei [6] = '{0, 1, 2, 0, 2, 3};
    int         ej [6] = '{1, 2, 0, 2, 3, 0};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    task automatic check(input string tag, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic longint wrapw(input longint v);
        longint m;
        m = v & ((longint'(1) << W) - 1);
        if (m >= (longint'(1) << (W - 1))) m = m - (longint'(1) << W);
        return m;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 6; k++) begin
            exp_e[k] = 0;
            exp_b[k] = 0;
        end
        exp_deg = 2'b00;
    endtask

    // Edge constants straight from E = a*x + b*y + c over each vertex pair.
    task automatic model_frame();
        longint c [6];
        for (int k = 0; k < 6; k++) begin
            c[k] = wrapw(longint'(vx[ej[k]]) * longint'(vy[ei[k]])
                       - longint'(vx[ei[k]]) * longint'(vy[ej[k]]));
            exp_b[k] = wrapw(longint'(vx[ei[k]]) - longint'(vx[ej[k]]));
        end
        exp_deg = 2'b00;
`ifdef DEGEN_CULL_EN
        for (int t = 0; t < 2; t++) begin
            if (wrapw(c[3*t] + c[3*t+1] + c[3*t+2]) == 0) begin
                exp_deg[t] = 1'b1;
                for (int k = 3*t; k < 3*t + 3; k++) begin
                    c[k]     = 0;
                    exp_b[k] = 0;
                end
            end
        end
`endif
        for (int k = 0; k < 6; k++) exp_e[k] = c[k];
    endtask

    task automatic drive_vtx();
        bus.x_screen_v0 = W'(vx[0]);
        bus.x_screen_v1 = W'(vx[1]);
        bus.x_screen_v2 = W'(vx[2]);
        bus.x_screen_v3 = W'(vx[3]);
        bus.y_screen_v0 = W'(vy[0]);
        bus.y_screen_v1 = W'(vy[1]);
        bus.y_screen_v2 = W'(vy[2]);
        bus.y_screen_v3 = W'(vy[3]);
    endtask

    task automatic scramble_vtx();
        bus.x_screen_v0 = W'($urandom);
        bus.x_screen_v1 = W'($urandom);
        bus.x_screen_v2 = W'($urandom);
        bus.x_screen_v3 = W'($urandom);
        bus.y_screen_v0 = W'($urandom);
        bus.y_screen_v1 = W'($urandom);
        bus.y_screen_v2 = W'($urandom);
        bus.y_screen_v3 = W'($urandom);
    endtask

    task automatic random_vtx();
        for (int k = 0; k < 4; k++) begin
            vx[k] = int'($urandom_range(0, 2000)) - 1000;
            vy[k] = int'($urandom_range(0, 2000)) - 1000;
        end
    endtask

    task automatic check_outs(input string tag);
        longint act [6];
        act[0] = bus.e0_init_t1;
        act[1] = bus.e1_init_t1;
        act[2] = bus.e2_init_t1;
        act[3] = bus.e0_init_t2;
        act[4] = bus.e1_init_t2;
        act[5] = bus.e2_init_t2;
        for (int k = 0; k < 6; k++) check($sformatf("%s_e%0d", tag, k), act[k], exp_e[k]);
        check({tag, "_degen"}, longint'(bus.tri_degen), longint'(exp_deg));
    endtask

    // Called on a negedge; trigger is held through the whole compute.
    task automatic do_frame(input string tag);
        int cnt;
        drive_vtx();
        bus.x = 10'd0;
        bus.y = 10'(V_VIS);
        model_frame();
        @(negedge clk);
        scramble_vtx();
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check({tag, "_busy_len"}, cnt, 14);
        check_outs(tag);
        bus.x = 10'd5;
        @(negedge clk);
    endtask

    task automatic do_line(input int yv, input int hold);
        bus.y = 10'(yv);
        bus.x = 10'd0;
        repeat (hold) @(negedge clk);
        bus.x = 10'd100;
        @(negedge clk);
        if (yv < V_VIS) begin
            for (int k = 0; k < 6; k++) exp_e[k] = wrapw(exp_e[k] + exp_b[k]);
        end
    endtask

    initial begin
        bus.x = 10'd100;
        bus.y = 10'd0;
        for (int k = 0; k < 4; k++) begin
            vx[k] = 0;
            vy[k] = 0;
        end
        drive_vtx();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        check_outs("reset");
        check("reset_busy", longint'(bus.busy), 0);
        reset = 1'b0;
        @(negedge clk);

        vx = '{10, 100, 10, 100};
        vy = '{10, 10, 100, 100};
        do_frame("dir");
        check("dir_lit_e0", bus.e0_init_t1, 900);
        check("dir_lit_e1", bus.e1_init_t1, -9900);
        check("dir_lit_e2", bus.e2_init_t1, 900);
        for (int n = 0; n < 5; n++) do_line(n, 2);
        check_outs("dir_lines");
        check("lines_lit_e0", bus.e0_init_t1, 450);
        check("lines_lit_e1", bus.e1_init_t1, -9450);
        check("lines_lit_e2", bus.e2_init_t1, 900);

        // Vertex change mid-frame keeps the latched b until the next trigger.
        vx[1] = 50;
        vy[1] = 50;
        drive_vtx();
        do_line(200, 1);
        check_outs("midchg");
        do_frame("newv");

        vx = '{0, 5, 10, 0};
        vy = '{0, 5, 10, 10};
        do_frame("degen");
        check("degen_lit", longint'(bus.tri_degen), longint'(DEGEN_LIT));
        for (int n = 0; n < 3; n++) begin
            do_line(n, 1);
            check_outs($sformatf("degen_l%0d", n));
        end

        // Abort during edge 3's MUL_N (9th busy cycle).
        random_vtx();
        drive_vtx();
        bus.x = 10'd0;
        bus.y = 10'(V_VIS);
        repeat (9) @(negedge clk);
        check("abort_busy_before", longint'(bus.busy), 1);
        reset = 1'b1;
        bus.x = 10'd5;
        @(negedge clk);
        model_reset();
        check("abort_busy", longint'(bus.busy), 0);
        check_outs("abort");
        reset = 1'b0;
        @(negedge clk);
        random_vtx();
        do_frame("after_abort");

        for (int f = 0; f < 20; f++) begin
            random_vtx();
            do_frame($sformatf("rf%0d", f));
            for (int n = 0; n < int'($urandom_range(1, 8)); n++) begin
                int yv;
                if ($urandom_range(0, 3) == 0) yv = int'($urandom_range(481, 524));
                else                           yv = int'($urandom_range(0, 479));
                do_line(yv, int'($urandom_range(1, 3)));
                check_outs($sformatf("rf%0d_l%0d", f, n));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
